// File: rtl/alu_pkg.sv
// alu_pkg
//   Definitions shared by the ALU control decoder, mc_alu and its sub-modules:
//   - 4-bit ALU op-code values
//   - mc_alu FSM state encoding (IDLE / SHIFT / DONE)
package alu_pkg;

  // ALU control op codes, as produced by the ALU control decoder
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1111;

  // mc_alu controller states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_logic_unit.sv
// alu_logic_unit
//   Purely combinational single-cycle ALU operations.
//   Ports:
//     op     in  4      ALU op code (alu_pkg::ALU_*)
//     a      in  WIDTH  operand A
//     b      in  WIDTH  operand B
//     result out WIDTH  AND/OR/ADD/SUB/SLT/NOR result; 0 for any other code
//   ADD/SUB wrap modulo 2^WIDTH. SLT is a signed compare. Shift codes are
//   not handled here and produce 0; the caller selects the shifter instead.
module alu_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  // Op decode for the one-cycle operations
  always_comb begin
    result = {WIDTH{1'b0}};
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: result = ~(a | b);
      default: result = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/mc_alu.sv
// mc_alu
//   Multi-cycle integer ALU. Logic/arithmetic ops complete in one cycle;
//   SLL/SRL use a one-bit-per-cycle serial shifter (latency 1+shamt).
//   Configuration macro: MC_ALU_BARREL_EN -- when defined, SLL/SRL use a
//   combinational barrel shifter and finish in one cycle; the SHIFT state
//   logic, shift register and counter are then not built.
//   Ports:
//     i_clk         in  1      clock, rising edge
//     i_rst         in  1      synchronous active-high reset
//     i_start       in  1      request pulse, accepted only when o_busy=0
//     i_aluControl  in  4      op code (alu_pkg::ALU_*)
//     i_a           in  WIDTH  operand A
//     i_b           in  WIDTH  operand B / shift source
//     i_shamt       in  SHW    shift amount for SLL/SRL
//     o_result      out WIDTH  registered result, held until next completion
//     o_zero        out 1      registered, o_result==0, updated with o_result
//     o_busy        out 1      high whenever the FSM is not IDLE
//     o_done        out 1      one-cycle completion pulse
module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_aluControl,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [SHW-1:0]   i_shamt,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_busy,
  output logic             o_done
);

  alu_state_e       state_r, state_n;
  logic [WIDTH-1:0] result_r, result_n;
  logic             zero_r, zero_n;
  logic             busy_r, done_r;
  logic [WIDTH-1:0] logic_res_s;
  logic             is_shift_s;
  logic             load_s;
  logic [WIDTH-1:0] load_val_s;

`ifndef MC_ALU_BARREL_EN
  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};
  logic [WIDTH-1:0] sh_r, sh_n, sh_step_s;
  logic [SHW-1:0]   cnt_r, cnt_n;
  logic             left_r, left_n;
`else
  logic [WIDTH-1:0] barrel_s;
`endif

  alu_logic_unit #(.WIDTH(WIDTH)) u_logic (
    .op     (i_aluControl),
    .a      (i_a),
    .b      (i_b),
    .result (logic_res_s)
  );

  assign is_shift_s = (i_aluControl == ALU_SLL) || (i_aluControl == ALU_SRL);

`ifndef MC_ALU_BARREL_EN
  // One-bit shift step of the serial shifter, logical with zero fill
  always_comb begin
    if (left_r) begin
      sh_step_s = {sh_r[WIDTH-2:0], 1'b0};
    end else begin
      sh_step_s = {1'b0, sh_r[WIDTH-1:1]};
    end
  end
`else
  // Single-cycle barrel shift of operand B
  always_comb begin
    if (i_aluControl == ALU_SLL) begin
      barrel_s = i_b << i_shamt;
    end else begin
      barrel_s = i_b >> i_shamt;
    end
  end
`endif

  // Next-state, result-load and shifter control
  always_comb begin
    state_n    = state_r;
    load_s     = 1'b0;
    load_val_s = {WIDTH{1'b0}};
`ifndef MC_ALU_BARREL_EN
    sh_n       = sh_r;
    cnt_n      = cnt_r;
    left_n     = left_r;
`endif
    case (state_r)
      IDLE: begin
        if (i_start) begin
          if (is_shift_s) begin
`ifdef MC_ALU_BARREL_EN
            load_s     = 1'b1;
            load_val_s = barrel_s;
            state_n    = DONE;
`else
            if (i_shamt == {SHW{1'b0}}) begin
              load_s     = 1'b1;
              load_val_s = i_b;
              state_n    = DONE;
            end else begin
              sh_n    = i_b;
              cnt_n   = i_shamt;
              left_n  = (i_aluControl == ALU_SLL);
              state_n = SHIFT;
            end
`endif
          end else begin
            load_s     = 1'b1;
            load_val_s = logic_res_s;
            state_n    = DONE;
          end
        end else begin
          state_n = IDLE;
        end
      end
`ifndef MC_ALU_BARREL_EN
      SHIFT: begin
        sh_n  = sh_step_s;
        cnt_n = cnt_r - CNT_ONE;
        // The counter holds the number of shifts still to do, so the
        // final shift happens while it reads one.
        if (cnt_r == CNT_ONE) begin
          load_s     = 1'b1;
          load_val_s = sh_step_s;
          state_n    = DONE;
        end else begin
          state_n = SHIFT;
        end
      end
`endif
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Result and zero flag move together and only when a result is loaded
  always_comb begin
    if (load_s) begin
      result_n = load_val_s;
      zero_n   = (load_val_s == {WIDTH{1'b0}});
    end else begin
      result_n = result_r;
      zero_n   = zero_r;
    end
  end

  // State and output registers; busy/done are registered from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= IDLE;
      result_r <= {WIDTH{1'b0}};
      zero_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      result_r <= result_n;
      zero_r   <= zero_n;
      busy_r   <= (state_n != IDLE);
      done_r   <= (state_n == DONE);
    end
  end

`ifndef MC_ALU_BARREL_EN
  // Serial shifter datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_r   <= {WIDTH{1'b0}};
      cnt_r  <= {SHW{1'b0}};
      left_r <= 1'b0;
    end else begin
      sh_r   <= sh_n;
      cnt_r  <= cnt_n;
      left_r <= left_n;
    end
  end
`endif

  assign o_result = result_r;
  assign o_zero   = zero_r;
  assign o_busy   = busy_r;
  assign o_done   = done_r;

endmodule
